// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline stage register carrying a datapath bundle and a control
//   bundle between two pipeline stages under a valid/ready handshake.
//
//   SKID=1 : two-entry buffer (main M + skid S), in_ready comes straight from
//            a flop, so full throughput is kept without a combinational
//            ready path from downstream to upstream.
//   SKID=0 : single register, in_ready = !M.valid | out_ready.
//
//   out_ctrl shows CTRL_BUBBLE (a NOP encoding) whenever out_valid is low, so
//   the next stage never sees stale control while no entry is presented.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous kill of all held entries (beats any transfer)
//   in_valid   upstream offers an entry
//   in_ready   stage accepts an entry this cycle
//   in_data    upstream datapath bundle   [DATA_W]
//   in_ctrl    upstream control bundle    [CTRL_W]
//   out_valid  head entry presented downstream
//   out_ready  downstream accepts the head entry
//   out_data   head entry datapath        [DATA_W]
//   out_ctrl   head entry control or CTRL_BUBBLE
//   occupancy  number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W      = 96,
  parameter int                CTRL_W      = 16,
  parameter int                SKID        = 1,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Main register: always the head of the queue and the only thing that
  // drives the outputs, which keeps in_* -> out_* free of combinational paths.
  logic              m_valid_reg, m_valid_next;
  logic [DATA_W-1:0] m_data_reg,  m_data_next;
  logic [CTRL_W-1:0] m_ctrl_reg,  m_ctrl_next;

  // Skid register: second-in-line entry. Constant-empty when SKID=0.
  logic              s_valid_reg, s_valid_next;
  logic [DATA_W-1:0] s_data_reg,  s_data_next;
  logic [CTRL_W-1:0] s_ctrl_reg,  s_ctrl_next;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_reg & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: space exists as long as the skid slot is free.
      assign in_ready  = ~s_valid_reg;
      assign occupancy = {m_valid_reg & s_valid_reg, m_valid_reg ^ s_valid_reg};

      always_comb begin
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_ctrl_next  = m_ctrl_reg;
        s_valid_next = s_valid_reg;
        s_data_next  = s_data_reg;
        s_ctrl_next  = s_ctrl_reg;

        if (flush) begin
          // Only the valid bits die; payload registers keep their contents.
          m_valid_next = 1'b0;
          s_valid_next = 1'b0;
        end else if (!m_valid_reg) begin
          // EMPTY
          if (in_fire) begin
            m_valid_next = 1'b1;
            m_data_next  = in_data;
            m_ctrl_next  = in_ctrl;
          end
        end else if (!s_valid_reg) begin
          // ONE
          if (in_fire && out_fire) begin
            m_data_next = in_data;
            m_ctrl_next = in_ctrl;
          end else if (in_fire) begin
            // Head is stalled: park the newcomer behind it.
            s_valid_next = 1'b1;
            s_data_next  = in_data;
            s_ctrl_next  = in_ctrl;
          end else if (out_fire) begin
            m_valid_next = 1'b0;
          end
        end else begin
          // FULL: in_ready is low, so only the drain side can move.
          if (out_fire) begin
            m_data_next  = s_data_reg;
            m_ctrl_next  = s_ctrl_reg;
            s_valid_next = 1'b0;
          end
        end
      end
    end else begin : g_single
      // Combinational ready: a full register can still take a new entry in
      // the same cycle its current one leaves.
      assign in_ready  = ~m_valid_reg | out_ready;
      assign occupancy = {1'b0, m_valid_reg};

      always_comb begin
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_ctrl_next  = m_ctrl_reg;
        s_valid_next = 1'b0;
        s_data_next  = s_data_reg;
        s_ctrl_next  = s_ctrl_reg;

        if (flush) begin
          m_valid_next = 1'b0;
        end else if (in_fire) begin
          m_valid_next = 1'b1;
          m_data_next  = in_data;
          m_ctrl_next  = in_ctrl;
        end else if (out_fire) begin
          m_valid_next = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_ctrl_reg  <= '0;
      s_valid_reg <= 1'b0;
      s_data_reg  <= '0;
      s_ctrl_reg  <= '0;
    end else begin
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      m_ctrl_reg  <= m_ctrl_next;
      s_valid_reg <= s_valid_next;
      s_data_reg  <= s_data_next;
      s_ctrl_reg  <= s_ctrl_next;
    end
  end

  assign out_valid = m_valid_reg;
  assign out_data  = m_data_reg;
  assign out_ctrl  = m_valid_reg ? m_ctrl_reg : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Two instances: dut (SKID=1, bubble 16'h0000) and dut_z (SKID=0, bubble
//   16'hBEEF). Each is shadowed by a queue model: the stage is a FIFO of
//   capacity 2 (SKID=1) or 1 (SKID=0), flush empties it, reset empties it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DW      = 96;
  localparam int          CW      = 16;
  localparam logic [15:0] BUB1    = 16'h0000;
  localparam logic [15:0] BUB0    = 16'hBEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  logic          flush_z = 1'b0;
  logic          in_valid_z = 1'b0;
  logic          in_ready_z;
  logic [DW-1:0] in_data_z = '0;
  logic [CW-1:0] in_ctrl_z = '0;
  logic          out_valid_z;
  logic          out_ready_z = 1'b0;
  logic [DW-1:0] out_data_z;
  logic [CW-1:0] out_ctrl_z;
  logic [1:0]    occupancy_z;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] qd[$];
  logic [CW-1:0] qc[$];
  logic [DW-1:0] qd0[$];
  logic [CW-1:0] qc0[$];
  logic [DW-1:0] got[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CTRL_BUBBLE(BUB1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CTRL_BUBBLE(BUB0)) dut_z (
    .clk(clk), .rst(rst), .flush(flush_z),
    .in_valid(in_valid_z), .in_ready(in_ready_z), .in_data(in_data_z), .in_ctrl(in_ctrl_z),
    .out_valid(out_valid_z), .out_ready(out_ready_z), .out_data(out_data_z), .out_ctrl(out_ctrl_z),
    .occupancy(occupancy_z)
  );

  task automatic clear_models();
    qd.delete(); qc.delete(); qd0.delete(); qc0.delete();
  endtask

  // Advance one clock edge and update both models from the handshake rules.
  task automatic step();
    bit            f1_in, f1_out, f0_in, f0_out, fl1, fl0;
    logic [DW-1:0] d1, d0;
    logic [CW-1:0] c1, c0;
    f1_in  = in_valid && (qd.size() < 2);
    f1_out = out_ready && (qd.size() > 0);
    f0_in  = in_valid_z && ((qd0.size() == 0) || out_ready_z);
    f0_out = out_ready_z && (qd0.size() > 0);
    fl1 = flush; fl0 = flush_z;
    d1 = in_data; c1 = in_ctrl; d0 = in_data_z; c0 = in_ctrl_z;
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    if (rst) begin
      clear_models();
    end else begin
      if (fl1) begin
        qd.delete(); qc.delete();
      end else begin
        if (f1_out) begin void'(qd.pop_front()); void'(qc.pop_front()); end
        if (f1_in)  begin qd.push_back(d1); qc.push_back(c1); end
      end
      if (fl0) begin
        qd0.delete(); qc0.delete();
      end else begin
        if (f0_out) begin void'(qd0.pop_front()); void'(qc0.pop_front()); end
        if (f0_in)  begin qd0.push_back(d0); qc0.push_back(c0); end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_ctrl !== BUB1) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=%h", out_ctrl, BUB1); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_ctrl_z !== BUB0) begin errors++; $display("FAIL reset_out_ctrl_z got=%h exp=%h", out_ctrl_z, BUB0); end
    step(); step();
    rst = 1'b0;
    clear_models();
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL post_reset_idle valid=%b occ=%0d exp valid=0 occ=0", out_valid, occupancy);
    end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = DW'(k); in_ctrl = CW'(k);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(k)) begin
        errors++; $display("FAIL stream_data k=%0d got valid=%b data=%0h exp valid=1 data=%0h", k, out_valid, out_data, k);
      end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_occ k=%0d got occ=%0d rdy=%b exp occ=1 rdy=1", k, occupancy, in_ready);
      end
      $display("stream beat %0d out_data=%0h occ=%0d", k, out_data, occupancy);
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL stream_drain got valid=%b occ=%0d exp 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int maxocc;
    bit acc;
    got.delete();
    k = 1; maxocc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = 1'b1;
      in_data  = DW'(256 + k);
      in_ctrl  = CW'(k);
      out_ready = !(cyc >= 4 && cyc < 7);
      acc = in_ready;
      step();
      if (acc) k++;
      if (qd.size() > maxocc) maxocc = qd.size();
      checks++; if (occupancy !== 2'(qd.size()) || in_ready !== (qd.size() < 2)) begin
        errors++; $display("FAIL bp_occ cyc=%0d got occ=%0d rdy=%b exp occ=%0d rdy=%b", cyc, occupancy, in_ready, qd.size(), qd.size() < 2);
      end
      if (qd.size() > 0) begin
        checks++; if (out_valid !== 1'b1 || out_data !== qd[0]) begin
          errors++; $display("FAIL bp_head cyc=%0d got valid=%b data=%0h exp valid=1 data=%0h", cyc, out_valid, out_data, qd[0]);
        end
      end
      $display("bp cyc %0d out_ready=%b occ=%0d in_ready=%b out_data=%0h", cyc, out_ready, occupancy, in_ready, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (maxocc != 2) begin errors++; $display("FAIL bp_maxocc got=%0d exp=2", maxocc); end
    checks++; if (got.size() != k - 1) begin
      errors++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), k - 1);
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++; if (got[i] !== DW'(257 + i)) begin
          errors++; $display("FAIL bp_order idx=%0d got=%0h exp=%0h", i, got[i], 257 + i);
        end
      end
    end
  endtask

  task automatic test_flush();
    got.delete();
    in_valid = 1'b1; out_ready = 1'b0;
    in_data = DW'(8'h11); in_ctrl = 16'h0011; step();
    in_data = DW'(8'h22); in_ctrl = 16'h0022; step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill got occ=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = DW'(8'hAA); in_ctrl = 16'h00AA; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== BUB1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full got valid=%b occ=%0d ctrl=%h rdy=%b exp 0/0/%h/1", out_valid, occupancy, out_ctrl, in_ready, BUB1);
    end
    // Flush from ONE with an accepted entry in the same cycle.
    in_valid = 1'b1; out_ready = 1'b0; in_data = DW'(8'h33); in_ctrl = 16'h0033; step();
    flush = 1'b1; in_data = DW'(8'hAA); in_ctrl = 16'h00AA; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== BUB1) begin
      errors++; $display("FAIL flush_one got valid=%b occ=%0d ctrl=%h exp 0/0/%h", out_valid, occupancy, out_ctrl, BUB1);
    end
    checks++; if (out_data !== DW'(8'h33)) begin
      errors++; $display("FAIL flush_data_hold got=%0h exp=33", out_data);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle i=%0d got valid=%b exp=0", i, out_valid); end
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] === DW'(8'hAA)) begin errors++; $display("FAIL flush_leak idx=%0d got=%0h exp not AA", i, got[i]); end
    end
    $display("test_flush done occ=%0d", occupancy);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_valid_z = 1'b1; out_ready_z = 1'b0;
    in_data = DW'(1); in_data_z = DW'(9); in_ctrl_z = 16'h1234; step();
    in_data = DW'(2); step();
    checks++; if (occupancy !== 2'd2 || occupancy_z !== 2'd1) begin
      errors++; $display("FAIL arst_prefill got occ=%0d occ_z=%0d exp 2/1", occupancy, occupancy_z);
    end
    #3 rst = 1'b1;
    clear_models();
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_immediate got valid=%b occ=%0d rdy=%b exp 0/0/1", out_valid, occupancy, in_ready);
    end
    checks++; if (out_ctrl !== BUB1 || out_data !== '0) begin
      errors++; $display("FAIL arst_payload got ctrl=%h data=%0h exp %h/0", out_ctrl, out_data, BUB1);
    end
    checks++; if (out_valid_z !== 1'b0 || out_ctrl_z !== BUB0 || occupancy_z !== 2'd0) begin
      errors++; $display("FAIL arst_z got valid=%b ctrl=%h occ=%0d exp 0/%h/0", out_valid_z, out_ctrl_z, occupancy_z, BUB0);
    end
    in_valid = 1'b0; in_valid_z = 1'b0;
    step();
    #3 rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_valid_z !== 1'b0) begin
      errors++; $display("FAIL arst_release got valid=%b occ=%0d valid_z=%b exp 0/0/0", out_valid, occupancy, out_valid_z);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_skid0();
    in_valid_z = 1'b1; out_ready_z = 1'b0; in_data_z = DW'(5); in_ctrl_z = 16'h0005;
    step();
    checks++; if (in_ready_z !== 1'b0 || occupancy_z !== 2'd1) begin
      errors++; $display("FAIL skid0_stall got rdy=%b occ=%0d exp 0/1", in_ready_z, occupancy_z);
    end
    out_ready_z = 1'b1; in_data_z = DW'(6); in_ctrl_z = 16'h0006;
    #1;
    checks++; if (in_ready_z !== 1'b1) begin errors++; $display("FAIL skid0_comb_ready got=%b exp=1", in_ready_z); end
    step();
    checks++; if (out_valid_z !== 1'b1 || out_data_z !== DW'(6) || occupancy_z !== 2'd1 || out_ctrl_z !== 16'h0006) begin
      errors++; $display("FAIL skid0_replace got valid=%b data=%0h occ=%0d ctrl=%h exp 1/6/1/0006", out_valid_z, out_data_z, occupancy_z, out_ctrl_z);
    end
    in_valid_z = 1'b0;
    step();
    checks++; if (occupancy_z !== 2'd0 || out_ctrl_z !== BUB0) begin
      errors++; $display("FAIL skid0_drain got occ=%0d ctrl=%h exp 0/%h", occupancy_z, out_ctrl_z, BUB0);
    end
    $display("test_skid0 done");
  endtask

  task automatic test_bubble();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_ctrl !== 16'h0000) begin errors++; $display("FAIL bubble_idle got=%h exp=0000", out_ctrl); end
    in_valid = 1'b1; in_ctrl = 16'h8421; in_data = DW'(77);
    step();
    in_valid = 1'b0;
    checks++; if (out_ctrl !== 16'h8421) begin errors++; $display("FAIL bubble_entry got=%h exp=8421", out_ctrl); end
    step();
    checks++; if (out_ctrl !== 16'h0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bubble_after got ctrl=%h valid=%b exp 0000/0", out_ctrl, out_valid);
    end
    $display("test_bubble done");
  endtask

  task automatic test_random();
    logic [CW-1:0] ec;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Upstream keeps an unaccepted offer stable.
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom};
        in_ctrl  = CW'($urandom);
      end
      if (!(in_valid_z && !in_ready_z)) begin
        in_valid_z = ($urandom_range(0, 3) != 0);
        in_data_z  = {$urandom, $urandom, $urandom};
        in_ctrl_z  = CW'($urandom);
      end
      out_ready   = ($urandom_range(0, 2) != 0);
      out_ready_z = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      flush_z = ($urandom_range(0, 15) == 0);
      step();
      ec = (qd.size() > 0) ? qc[0] : BUB1;
      checks++; if (out_valid !== (qd.size() > 0) || occupancy !== 2'(qd.size()) || in_ready !== (qd.size() < 2) || out_ctrl !== ec) begin
        errors++; $display("FAIL rand_skid1 cyc=%0d got v=%b occ=%0d rdy=%b ctrl=%h exp v=%b occ=%0d rdy=%b ctrl=%h",
                           cyc, out_valid, occupancy, in_ready, out_ctrl, qd.size() > 0, qd.size(), qd.size() < 2, ec);
      end
      if (qd.size() > 0) begin
        checks++; if (out_data !== qd[0]) begin errors++; $display("FAIL rand_data1 cyc=%0d got=%h exp=%h", cyc, out_data, qd[0]); end
      end
      ec = (qd0.size() > 0) ? qc0[0] : BUB0;
      checks++; if (out_valid_z !== (qd0.size() > 0) || occupancy_z !== 2'(qd0.size()) || out_ctrl_z !== ec) begin
        errors++; $display("FAIL rand_skid0 cyc=%0d got v=%b occ=%0d ctrl=%h exp v=%b occ=%0d ctrl=%h",
                           cyc, out_valid_z, occupancy_z, out_ctrl_z, qd0.size() > 0, qd0.size(), ec);
      end
      if (qd0.size() > 0) begin
        checks++; if (out_data_z !== qd0[0]) begin errors++; $display("FAIL rand_data0 cyc=%0d got=%h exp=%h", cyc, out_data_z, qd0[0]); end
      end
      if (cyc % 50 == 0) $display("rand cyc %0d occ=%0d occ_z=%0d", cyc, occupancy, occupancy_z);
    end
    flush = 1'b0; flush_z = 1'b0; in_valid = 1'b0; in_valid_z = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_skid0();
    test_bubble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
